// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and the fetch queue entry type
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam logic [FETCH_DATA_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/mem_fetch_q_if.sv
// rtl/mem_fetch_q_if.sv - redirect, instruction memory and decode handshake bundle
interface mem_fetch_q_if #(
  parameter int ADDR_W  = fetch_pkg::FETCH_ADDR_W,
  parameter int DATA_W  = fetch_pkg::FETCH_DATA_W,
  parameter int IMEM_AW = 10
);

  logic               i_redirect;
  logic [ADDR_W-1:0]  i_redirect_pc;
  logic               o_imem_en;
  logic [IMEM_AW-1:0] o_imem_addr;
  logic [DATA_W-1:0]  i_imem_dout;
  logic               o_valid;
  logic               i_ready;
  logic [DATA_W-1:0]  o_instr;
  logic [ADDR_W-1:0]  o_pc;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_dout, i_ready,
    output o_imem_en, o_imem_addr, o_valid, o_instr, o_pc
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_dout, i_ready,
    input  o_imem_en, o_imem_addr, o_valid, o_instr, o_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - flushable FIFO of fetched {pc, instr} entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_fetch_q.sv
// rtl/mem_fetch_q.sv - PC owner, memory issue logic and queued delivery to decode
module mem_fetch_q
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int DATA_W  = FETCH_DATA_W,
  parameter int IMEM_AW = 10,
  parameter int DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  mem_fetch_q_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;

  logic [CW-1:0] fifo_count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          valid, push, pop, issue;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsbs;

  assign valid = (fifo_count != '0);
  assign pop   = valid & bus.i_ready & ~bus.i_redirect;
  assign push  = inflight_q & ~bus.i_redirect;

  // Counting the pop lets a slot freed this cycle be refilled without a bubble.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue     = ~rst & ~bus.i_redirect & (occupancy < (CW + 1)'(DEPTH));

  assign push_data = '{pc: req_pc_q, instr: bus.i_imem_dout};
  assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (bus.i_redirect) begin
      pc_d = {bus.i_redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      pc_d       = pc_q + ADDR_W'(4);
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.i_redirect),
    .count     (fifo_count),
    .head      (head)
  );

  assign bus.o_imem_en   = issue;
  assign bus.o_imem_addr = pc_q[IMEM_AW+1:2];
  assign bus.o_valid     = valid;
  assign bus.o_instr     = valid ? head.instr : INSTR_NOP;
  assign bus.o_pc        = valid ? head.pc : '0;

endmodule

// File: tb/tb_mem_fetch_q.sv
// tb/tb_mem_fetch_q.sv - directed self-checking bench for mem_fetch_q
module tb_mem_fetch_q;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] mem_dout;
  logic [31:0] exp_pc;

  mem_fetch_q_if #(.ADDR_W(32), .DATA_W(32), .IMEM_AW(10)) bus ();

  mem_fetch_q #(
    .ADDR_W(32), .DATA_W(32), .IMEM_AW(10), .DEPTH(2), .RESET_PC(32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns its own word address as data.
  always @(posedge clk) if (bus.o_imem_en) mem_dout <= {22'b0, bus.o_imem_addr};
  assign bus.i_imem_dout = mem_dout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.i_redirect = 1'b0; bus.i_redirect_pc = '0; bus.i_ready = 1'b1;
    tick(); tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid actual=%0h required=0", bus.o_valid); end
    n_checks++; if (bus.o_imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_en actual=%0h required=0", bus.o_imem_en); end
    n_checks++; if (bus.o_instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr actual=%0h required=13", bus.o_instr); end
    n_checks++; if (bus.o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc actual=%0h required=0", bus.o_pc); end
    tick(); rst = 1'b0; #1;
    n_checks++; if (bus.o_imem_en !== 1'b1) begin n_fail++; $display("FAIL first_en actual=%0h required=1", bus.o_imem_en); end
    n_checks++; if (bus.o_imem_addr !== 10'h040) begin n_fail++; $display("FAIL first_addr actual=%0h required=40", bus.o_imem_addr); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL cycle2_valid actual=%0h required=0", bus.o_valid); end
    n_checks++; if (bus.o_imem_addr !== 10'h041) begin n_fail++; $display("FAIL cycle2_addr actual=%0h required=41", bus.o_imem_addr); end
    exp_pc = 32'h100;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d actual=%0h required=1", k, bus.o_valid); end
      n_checks++; if (bus.o_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc k=%0d actual=%0h required=%0h", k, bus.o_pc, exp_pc); end
      n_checks++; if (bus.o_instr !== {22'b0, exp_pc[11:2]}) begin n_fail++; $display("FAIL stream_instr k=%0d actual=%0h required=%0h", k, bus.o_instr, {22'b0, exp_pc[11:2]}); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 6; i++) begin
      tick(); bus.i_ready = 1'b0; #1;
      n_checks++; if (bus.o_imem_en !== 1'b0) begin n_fail++; $display("FAIL stall_en i=%0d actual=%0h required=0", i, bus.o_imem_en); end
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid i=%0d actual=%0h required=1", i, bus.o_valid); end
      n_checks++; if (bus.o_pc !== exp_pc) begin n_fail++; $display("FAIL stall_pc i=%0d actual=%0h required=%0h", i, bus.o_pc, exp_pc); end
      n_checks++; if (bus.o_instr !== {22'b0, exp_pc[11:2]}) begin n_fail++; $display("FAIL stall_instr i=%0d actual=%0h required=%0h", i, bus.o_instr, {22'b0, exp_pc[11:2]}); end
    end
    for (int k = 0; k < 6; k++) begin
      tick(); bus.i_ready = 1'b1; #1;
      n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid k=%0d actual=%0h required=1", k, bus.o_valid); end
      n_checks++; if (bus.o_pc !== exp_pc) begin n_fail++; $display("FAIL resume_pc k=%0d actual=%0h required=%0h", k, bus.o_pc, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    tick(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h203; #1;
    n_checks++; if (bus.o_imem_en !== 1'b0) begin n_fail++; $display("FAIL redir_en actual=%0h required=0", bus.o_imem_en); end
    tick(); bus.i_redirect = 1'b0; #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_r1_valid actual=%0h required=0", bus.o_valid); end
    n_checks++; if (bus.o_imem_addr !== 10'h080 || bus.o_imem_en !== 1'b1) begin n_fail++; $display("FAIL redir_r1_addr actual=%0h en=%0h required=80 en=1", bus.o_imem_addr, bus.o_imem_en); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_r2_valid actual=%0h required=0", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h200 || bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL redir_r3_pc actual=%0h valid=%0h required=200 valid=1", bus.o_pc, bus.o_valid); end
    n_checks++; if (bus.o_instr !== 32'h80) begin n_fail++; $display("FAIL redir_r3_instr actual=%0h required=80", bus.o_instr); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h204) begin n_fail++; $display("FAIL redir_r4_pc actual=%0h required=204", bus.o_pc); end
  endtask

  task automatic test_redirect_pop();
    tick(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h300; #1;
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 32'h208) begin n_fail++; $display("FAIL rpop_head actual=%0h valid=%0h required=208 valid=1", bus.o_pc, bus.o_valid); end
    tick(); bus.i_redirect = 1'b0; #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_r1_valid actual=%0h required=0", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_r2_valid actual=%0h required=0", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h300 || bus.o_instr !== 32'hC0) begin n_fail++; $display("FAIL rpop_target actual=%0h/%0h required=300/c0", bus.o_pc, bus.o_instr); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h304) begin n_fail++; $display("FAIL rpop_next actual=%0h required=304", bus.o_pc); end
  endtask

  task automatic test_back_to_back();
    tick(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h400; #1;
    n_checks++; if (bus.o_imem_en !== 1'b0) begin n_fail++; $display("FAIL b2b_first_en actual=%0h required=0", bus.o_imem_en); end
    tick(); bus.i_redirect_pc = 32'h500; #1;
    n_checks++; if (bus.o_imem_en !== 1'b0) begin n_fail++; $display("FAIL b2b_second_en actual=%0h required=0", bus.o_imem_en); end
    tick(); bus.i_redirect = 1'b0; #1;
    n_checks++; if (bus.o_imem_en !== 1'b1 || bus.o_imem_addr !== 10'h140) begin n_fail++; $display("FAIL b2b_issue actual=%0h en=%0h required=140 en=1", bus.o_imem_addr, bus.o_imem_en); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_valid actual=%0h required=0", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h500 || bus.o_instr !== 32'h140) begin n_fail++; $display("FAIL b2b_target actual=%0h/%0h required=500/140", bus.o_pc, bus.o_instr); end
  endtask

  task automatic test_wrap();
    tick(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'hFFFF_FFF8; #1;
    tick(); bus.i_redirect = 1'b0; #1;
    n_checks++; if (bus.o_imem_addr !== 10'h3FE) begin n_fail++; $display("FAIL wrap_addr0 actual=%0h required=3fe", bus.o_imem_addr); end
    tick();
    n_checks++; if (bus.o_imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL wrap_addr1 actual=%0h required=3ff", bus.o_imem_addr); end
    tick();
    n_checks++; if (bus.o_imem_addr !== 10'h000) begin n_fail++; $display("FAIL wrap_addr2 actual=%0h required=0", bus.o_imem_addr); end
    n_checks++; if (bus.o_pc !== 32'hFFFF_FFF8 || bus.o_instr !== 32'h3FE) begin n_fail++; $display("FAIL wrap_pc0 actual=%0h/%0h required=fffffff8/3fe", bus.o_pc, bus.o_instr); end
    tick();
    n_checks++; if (bus.o_pc !== 32'hFFFF_FFFC || bus.o_instr !== 32'h3FF) begin n_fail++; $display("FAIL wrap_pc1 actual=%0h/%0h required=fffffffc/3ff", bus.o_pc, bus.o_instr); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h0 || bus.o_instr !== 32'h0 || bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pc2 actual=%0h/%0h valid=%0h required=0/0 valid=1", bus.o_pc, bus.o_instr, bus.o_valid); end
  endtask

  task automatic test_reset_mid();
    tick(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h600; bus.i_ready = 1'b0; #1;
    tick(); bus.i_redirect = 1'b0; #1;
    tick();
    tick();
    n_checks++; if (bus.o_imem_en !== 1'b0 || bus.o_pc !== 32'h600) begin n_fail++; $display("FAIL mid_full actual=%0h en=%0h required=600 en=0", bus.o_pc, bus.o_imem_en); end
    rst = 1'b1; #1;
    n_checks++; if (bus.o_valid !== 1'b0 || bus.o_imem_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst actual=valid %0h en %0h required=0 0", bus.o_valid, bus.o_imem_en); end
    n_checks++; if (bus.o_instr !== 32'h13) begin n_fail++; $display("FAIL mid_rst_instr actual=%0h required=13", bus.o_instr); end
    tick(); tick(); rst = 1'b0; bus.i_ready = 1'b1; #1;
    n_checks++; if (bus.o_imem_en !== 1'b1 || bus.o_imem_addr !== 10'h040) begin n_fail++; $display("FAIL mid_restart actual=%0h en=%0h required=40 en=1", bus.o_imem_addr, bus.o_imem_en); end
    tick();
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid actual=%0h required=0", bus.o_valid); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h100 || bus.o_instr !== 32'h40) begin n_fail++; $display("FAIL mid_first actual=%0h/%0h required=100/40", bus.o_pc, bus.o_instr); end
    tick();
    n_checks++; if (bus.o_pc !== 32'h104) begin n_fail++; $display("FAIL mid_second actual=%0h required=104", bus.o_pc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
